// File: rtl/i2c_reg_bank_controller_if.sv
// rtl/i2c_reg_bank_controller_if.sv - I2C slave sequencing and host register port bundle
interface i2c_reg_bank_controller_if #(
    parameter int PW = 4
);
    logic          enable;
    logic [7:0]    slv_data_read;
    logic          slv_read_write_flag;
    logic          slv_data_finish;
    logic          slv_transfer_status;
    logic          slv_error;
    logic [7:0]    slv_data_write;
    logic [PW-1:0] host_addr;
    logic [7:0]    host_wdata;
    logic          host_we;
    logic [7:0]    host_rdata;
    logic          reg_update;
    logic [PW-1:0] update_index;
    logic          busy;
    logic [3:0]    err_count;

    modport slave (
        input  enable, slv_data_read, slv_read_write_flag, slv_data_finish,
               slv_transfer_status, slv_error, host_addr, host_wdata, host_we,
        output slv_data_write, host_rdata, reg_update, update_index, busy, err_count
    );

    modport master (
        output enable, slv_data_read, slv_read_write_flag, slv_data_finish,
               slv_transfer_status, slv_error, host_addr, host_wdata, host_we,
        input  slv_data_write, host_rdata, reg_update, update_index, busy, err_count
    );
endinterface

// File: rtl/i2c_reg_bank_controller.sv
// rtl/i2c_reg_bank_controller.sv - register bank shared by an I2C slave sequencer and a host port
module i2c_reg_bank_controller #(
    parameter int REG_COUNT = 16
) (
    input  logic                         clock,
    input  logic                         reset_n,
    i2c_reg_bank_controller_if.slave     bus
);
    localparam int PW = $clog2(REG_COUNT);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        GET_PTR    = 2'd1,
        WRITE_DATA = 2'd2,
        READ_DATA  = 2'd3
    } state_t;

    state_t        state, state_next;
    logic [PW-1:0] pointer, ptr_next;
    logic [7:0]    regs [REG_COUNT];
    logic          xfer_d;
    logic          xfer_rise;
    logic          i2c_we;
    logic [7:0]    data_write_q;
    logic          reg_update_q;
    logic [PW-1:0] update_index_q;
    logic [3:0]    err_count_q;

    // xfer_d resets high so a transfer already in progress across reset is not seen as a new start
    assign xfer_rise = bus.slv_transfer_status & ~xfer_d;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            pointer <= '0;
            xfer_d  <= 1'b1;
        end else begin
            state   <= state_next;
            pointer <= ptr_next;
            xfer_d  <= bus.slv_transfer_status;
        end
    end

    always_comb begin
        state_next = state;
        ptr_next   = pointer;
        i2c_we     = 1'b0;
        if (!bus.enable || bus.slv_error) begin
            state_next = IDLE;
        end else if (state != IDLE && !bus.slv_transfer_status) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (xfer_rise)
                        state_next = bus.slv_read_write_flag ? GET_PTR : READ_DATA;
                end
                GET_PTR: begin
                    if (bus.slv_data_finish) begin
                        ptr_next   = bus.slv_data_read[PW-1:0];
                        state_next = WRITE_DATA;
                    end
                end
                WRITE_DATA: begin
                    if (bus.slv_data_finish) begin
                        i2c_we   = 1'b1;
                        ptr_next = pointer + PW'(1);
                    end
                end
                READ_DATA: begin
                    if (bus.slv_data_finish)
                        ptr_next = pointer + PW'(1);
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // The I2C write is applied after the host write so it wins on an index collision
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < REG_COUNT; i++)
                regs[i] <= 8'h00;
        end else begin
            if (bus.host_we)
                regs[bus.host_addr] <= bus.host_wdata;
            if (i2c_we)
                regs[pointer] <= bus.slv_data_read;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            data_write_q   <= 8'h00;
            reg_update_q   <= 1'b0;
            update_index_q <= '0;
            err_count_q    <= 4'h0;
        end else begin
            data_write_q   <= regs[pointer];
            reg_update_q   <= i2c_we;
            update_index_q <= pointer;
            if (bus.slv_error && err_count_q != 4'hF)
                err_count_q <= err_count_q + 4'd1;
        end
    end

    assign bus.slv_data_write = data_write_q;
    assign bus.host_rdata     = regs[bus.host_addr];
    assign bus.reg_update     = reg_update_q;
    assign bus.update_index   = update_index_q;
    assign bus.busy           = (state != IDLE);
    assign bus.err_count      = err_count_q;
endmodule

// File: tb/tb_i2c_reg_bank_controller.sv
// tb/tb_i2c_reg_bank_controller.sv - directed self-checking bench for i2c_reg_bank_controller
module tb_i2c_reg_bank_controller;
    logic clock = 1'b0;
    logic reset_n;
    int   n_asserts = 0;
    int   n_fail = 0;
    logic       upd;
    logic [3:0] idx;

    i2c_reg_bank_controller_if ifc ();

    i2c_reg_bank_controller #(.REG_COUNT(16)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (ifc)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reg(input string tag, input logic [3:0] a, input logic [7:0] exp);
        ifc.host_addr = a;
        #1;
        check(tag, {24'h0, ifc.host_rdata}, {24'h0, exp});
    endtask

    task automatic host_write(input logic [3:0] a, input logic [7:0] d);
        ifc.host_addr  = a;
        ifc.host_wdata = d;
        ifc.host_we    = 1'b1;
        tick();
        ifc.host_we    = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, output logic u, output logic [3:0] ix);
        ifc.slv_data_read   = b;
        ifc.slv_data_finish = 1'b1;
        tick();
        u  = ifc.reg_update;
        ix = ifc.update_index;
        ifc.slv_data_finish = 1'b0;
        tick();
    endtask

    task automatic start_xfer(input logic rw);
        ifc.slv_read_write_flag = rw;
        ifc.slv_transfer_status = 1'b1;
        tick();
    endtask

    task automatic end_xfer();
        ifc.slv_transfer_status = 1'b0;
        tick();
    endtask

    initial begin
        reset_n                 = 1'b0;
        ifc.enable              = 1'b0;
        ifc.slv_data_read       = 8'h00;
        ifc.slv_read_write_flag = 1'b0;
        ifc.slv_data_finish     = 1'b0;
        ifc.slv_transfer_status = 1'b0;
        ifc.slv_error           = 1'b0;
        ifc.host_addr           = 4'h0;
        ifc.host_wdata          = 8'h00;
        ifc.host_we             = 1'b0;
        tick();
        check("reset_busy", {31'h0, ifc.busy}, 32'h0);
        check("reset_err_count", {28'h0, ifc.err_count}, 32'h0);
        check("reset_data_write", {24'h0, ifc.slv_data_write}, 32'h0);
        check("reset_reg_update", {31'h0, ifc.reg_update}, 32'h0);
        check_reg("reset_reg0", 4'h0, 8'h00);
        reset_n = 1'b1;
        tick();

        // Write 0xA5, 0x5A starting at pointer 3
        host_write(4'h5, 8'h66);
        ifc.enable = 1'b1;
        start_xfer(1'b1);
        check("wr_busy", {31'h0, ifc.busy}, 32'h1);
        send_byte(8'h03, upd, idx);
        check("wr_ptr_no_update", {31'h0, upd}, 32'h0);
        send_byte(8'hA5, upd, idx);
        check("wr_upd1", {27'h0, upd, idx}, {27'h0, 1'b1, 4'h3});
        send_byte(8'h5A, upd, idx);
        check("wr_upd2", {27'h0, upd, idx}, {27'h0, 1'b1, 4'h4});
        check("wr_upd_cleared", {31'h0, ifc.reg_update}, 32'h0);
        check("wr_ptr5_data", {24'h0, ifc.slv_data_write}, 32'h66);
        check_reg("wr_reg3", 4'h3, 8'hA5);
        check_reg("wr_reg4", 4'h4, 8'h5A);
        end_xfer();
        check("wr_idle", {31'h0, ifc.busy}, 32'h0);

        // Pointer wrap 15 -> 0
        host_write(4'h1, 8'h77);
        start_xfer(1'b1);
        send_byte(8'h0F, upd, idx);
        send_byte(8'h11, upd, idx);
        check("wrap_upd1", {27'h0, upd, idx}, {27'h0, 1'b1, 4'hF});
        send_byte(8'h22, upd, idx);
        check("wrap_upd2", {27'h0, upd, idx}, {27'h0, 1'b1, 4'h0});
        check("wrap_ptr1_data", {24'h0, ifc.slv_data_write}, 32'h77);
        check_reg("wrap_reg15", 4'hF, 8'h11);
        check_reg("wrap_reg0", 4'h0, 8'h22);
        end_xfer();

        // Pointer write, then repeated start as read
        host_write(4'h2, 8'h13);
        host_write(4'h3, 8'h57);
        start_xfer(1'b1);
        send_byte(8'h02, upd, idx);
        end_xfer();
        start_xfer(1'b0);
        check("rd_busy", {31'h0, ifc.busy}, 32'h1);
        check("rd_first", {24'h0, ifc.slv_data_write}, 32'h13);
        send_byte(8'h00, upd, idx);
        check("rd_no_update", {31'h0, upd}, 32'h0);
        check("rd_second", {24'h0, ifc.slv_data_write}, 32'h57);
        check_reg("rd_reg2_kept", 4'h2, 8'h13);
        end_xfer();

        // Host/I2C collision on the same index, then on different indices
        start_xfer(1'b1);
        send_byte(8'h04, upd, idx);
        ifc.host_addr       = 4'h4;
        ifc.host_wdata      = 8'hFF;
        ifc.host_we         = 1'b1;
        ifc.slv_data_read   = 8'h44;
        ifc.slv_data_finish = 1'b1;
        tick();
        ifc.host_we         = 1'b0;
        ifc.slv_data_finish = 1'b0;
        tick();
        check_reg("coll_same_i2c_wins", 4'h4, 8'h44);
        ifc.host_addr       = 4'h9;
        ifc.host_wdata      = 8'h99;
        ifc.host_we         = 1'b1;
        ifc.slv_data_read   = 8'h55;
        ifc.slv_data_finish = 1'b1;
        tick();
        ifc.host_we         = 1'b0;
        ifc.slv_data_finish = 1'b0;
        tick();
        check_reg("coll_diff_i2c", 4'h5, 8'h55);
        check_reg("coll_diff_host", 4'h9, 8'h99);
        end_xfer();

        // Error with simultaneous finish during WRITE_DATA
        start_xfer(1'b1);
        send_byte(8'h06, upd, idx);
        ifc.slv_data_read   = 8'hEE;
        ifc.slv_data_finish = 1'b1;
        ifc.slv_error       = 1'b1;
        tick();
        ifc.slv_data_finish = 1'b0;
        ifc.slv_error       = 1'b0;
        check("err_idle", {31'h0, ifc.busy}, 32'h0);
        check("err_count1", {28'h0, ifc.err_count}, 32'h1);
        check("err_no_update", {31'h0, ifc.reg_update}, 32'h0);
        check_reg("err_no_write", 4'h6, 8'h00);
        tick();
        check("err_stays_idle", {31'h0, ifc.busy}, 32'h0);
        end_xfer();

        // Finish pulse in IDLE is ignored
        send_byte(8'hC3, upd, idx);
        check("idle_finish_no_update", {31'h0, upd}, 32'h0);
        check("idle_finish_busy", {31'h0, ifc.busy}, 32'h0);

        // Disabled: starts ignored, errors still counted
        ifc.enable = 1'b0;
        start_xfer(1'b1);
        check("dis_busy", {31'h0, ifc.busy}, 32'h0);
        ifc.slv_error = 1'b1;
        tick();
        ifc.slv_error = 1'b0;
        check("dis_err_count", {28'h0, ifc.err_count}, 32'h2);
        end_xfer();
        ifc.enable = 1'b1;
        for (int i = 0; i < 16; i++) begin
            ifc.slv_error = 1'b1;
            tick();
            ifc.slv_error = 1'b0;
            tick();
        end
        check("err_saturate", {28'h0, ifc.err_count}, 32'hF);

        // Reset mid WRITE_DATA
        start_xfer(1'b1);
        send_byte(8'h08, upd, idx);
        ifc.slv_data_read = 8'hAB;
        reset_n = 1'b0;
        #1;
        check("rst_busy", {31'h0, ifc.busy}, 32'h0);
        check("rst_err_count", {28'h0, ifc.err_count}, 32'h0);
        check("rst_data_write", {24'h0, ifc.slv_data_write}, 32'h0);
        check("rst_outputs", {27'h0, ifc.reg_update, ifc.update_index}, 32'h0);
        check_reg("rst_reg3", 4'h3, 8'h00);
        check_reg("rst_reg4", 4'h4, 8'h00);
        tick();
        reset_n = 1'b1;
        tick();
        check("rst_no_restart", {31'h0, ifc.busy}, 32'h0);
        send_byte(8'hAB, upd, idx);
        check_reg("rst_no_write", 4'h0, 8'h00);
        end_xfer();
        start_xfer(1'b1);
        check("rst_new_start", {31'h0, ifc.busy}, 32'h1);
        end_xfer();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule

// File: doc/i2c_reg_bank_controller.md
I2C_REG_BANK_CONTROLLER -- requirements
Module: i2c_reg_bank_controller

Interface
REQ-001 SHALL have parameter REG_COUNT, default 16, number of 8-bit registers in the bank (fixed power of two; pointer width PW = log2(REG_COUNT) = 4).
REQ-002 SHALL have port clock  input  1  single system clock, all logic on rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port enable  input  1  1 = I2C side sequencing active; 0 = I2C side idle.
REQ-005 SHALL have port slv_data_read  input  8  byte received by I2C_slave from the bus master.
REQ-006 SHALL have port slv_read_write_flag  input  1  1 = slave receiving bytes from master, 0 = slave transmitting bytes to master; valid while slv_transfer_status = 1.
REQ-007 SHALL have port slv_data_finish  input  1  one-cycle pulse, current byte (received or transmitted) complete.
REQ-008 SHALL have port slv_transfer_status  input  1  1 while an addressed transaction is in progress.
REQ-009 SHALL have port slv_error  input  1  one-cycle pulse, bus or protocol error reported by I2C_slave.
REQ-010 SHALL have port slv_data_write  output  8  next byte for I2C_slave to transmit.
REQ-011 SHALL have port host_addr  input  4  host register index.
REQ-012 SHALL have port host_wdata  input  8  host write data.
REQ-013 SHALL have port host_we  input  1  host write strobe, one register write per asserted cycle.
REQ-014 SHALL have port host_rdata  output  8  combinational read of reg[host_addr].
REQ-015 SHALL have port reg_update  output  1  one-cycle pulse, I2C master wrote a register.
REQ-016 SHALL have port update_index  output  4  index written, valid while reg_update = 1.
REQ-017 SHALL have port busy  output  1  1 when state is not IDLE.
REQ-018 SHALL have port err_count  output  4  saturating count of slv_error pulses.

Function
REQ-019 SHALL implement states IDLE, GET_PTR, WRITE_DATA, READ_DATA; busy = (state != IDLE).
REQ-020 SHALL transition IDLE->GET_PTR on slv_transfer_status rising edge with slv_read_write_flag = 1, and IDLE->READ_DATA on rising edge with slv_read_write_flag = 0 (edge detected against a one-cycle-delayed copy).
REQ-021 SHALL, in GET_PTR on slv_data_finish, load pointer <= slv_data_read[3:0] (bits [7:4] ignored) and move to WRITE_DATA.
REQ-022 SHALL, in WRITE_DATA on slv_data_finish, write reg[pointer] <= slv_data_read and pointer <= pointer+1 mod 16 (15 wraps to 0), reg_update = 1 and update_index = old pointer in the following cycle.
REQ-023 SHALL, in READ_DATA on slv_data_finish, advance pointer <= pointer+1 mod 16 with no register change.
REQ-024 SHALL register slv_data_write <= reg[pointer] every cycle (one-cycle latency after pointer or register change).
REQ-025 SHALL return to IDLE from any state when slv_transfer_status falls; pointer retained so a pointer-write followed by repeated start/read reads from that pointer.
REQ-026 SHALL, on slv_error, go to IDLE next cycle, retain pointer, discard any simultaneous slv_data_finish, and increment err_count saturating at 15.
REQ-027 SHALL, when enable = 0, hold state IDLE, ignore all slv_* inputs except counting slv_error; host port remains functional.
REQ-028 SHALL, when host_we and an I2C register write target the same index in the same cycle, keep the I2C value; different indices both write.
REQ-029 SHALL ignore slv_data_finish in IDLE.

Reset
REQ-030 SHALL, on reset_n low, asynchronously clear state to IDLE, pointer, all registers, slv_data_write, reg_update, update_index, err_count to 0; busy = 0.
REQ-031 SHALL, on reset mid-transaction, abandon the transaction with no partial register write and restart only on the next slv_transfer_status rising edge.

Verification
REQ-032 Write: transfer rise rw=1, bytes 0x03,0xA5,0x5A -> reg[3]=0xA5, reg[4]=0x5A, two reg_update pulses index 3 then 4, pointer = 5.
REQ-033 Wrap: pointer byte 0x0F, data 0x11,0x22 -> reg[15]=0x11, reg[0]=0x22, pointer = 1.
REQ-034 Combined: write pointer 0x02 only, transfer falls, rise rw=0, regs 2/3 = 0x13/0x57 -> slv_data_write 0x13, after finish 0x57.
REQ-035 Collision: host_we index 4 data 0xFF same cycle as I2C write 0x44 to index 4 -> reg[4]=0x44.
REQ-036 Error: slv_error during WRITE_DATA with simultaneous finish -> no write, state IDLE, err_count 1; 16 further errors -> err_count 15.
REQ-037 Reset: reset_n low mid WRITE_DATA -> all outputs 0, busy 0, registers 0.
